sram_gpio_regs: RTL and testbench
=================================

// Module: sram_gpio_regs
// PURPOSE
//  GPIO register bank on the CPU SRAM-bus path. Sits directly downstream of sram_bus and consumes its
//  clk-synchronous single-cycle read/write strobes. Drives NGPIO pins with per-bit direction, and
//  samples the pins through synchronizers. Raises an edge-triggered, maskable interrupt to the CPU.
// PARAMETERS
//  NGPIO      8        number of GPIO bits; equals bus data width, 1..8
//  ADDR_W     13       width of the sram_bus address
//  BLOCK_SEL  10'h000  value of addr[ADDR_W-1:3] that selects this bank
// PORTS
//  clk        in   1       system clock
//  reset      in   1       asynchronous, active-high reset
//  wr_stb     in   1       one-cycle write strobe from sram_bus
//  rd_stb     in   1       one-cycle read strobe from sram_bus
//  addr       in   ADDR_W  bus address, valid while either strobe is high
//  wr_data    in   8       write data, valid with wr_stb
//  rd_data    out  8       registered read data
//  rd_valid   out  1       one-cycle pulse, rd_data updated
//  gpio_in    in   NGPIO   asynchronous pin inputs
//  gpio_out   out  NGPIO   pin output values (DATA_OUT)
//  gpio_oe    out  NGPIO   pin output enables (DIR), 1 = drive
//  irq        out  1       level interrupt to CPU
// BEHAVIOUR
//  Reset: all registers, rd_data, rd_valid, gpio_out, gpio_oe, irq and sync flops go to 0 (all pins are inputs).
//  Selection: a strobe is accepted only when addr[ADDR_W-1:3]==BLOCK_SEL. Otherwise it is ignored.
//    An unselected read still pulses rd_valid, with rd_data=0.
//  Register map, addr[2:0]:
//    0 DATA_OUT   RW
//    1 DIR        RW
//    2 PIN_IN     RO (synced pins)
//    3 IRQ_EN     RW
//    4 IRQ_EDGE   RW (1 = rising, 0 = falling)
//    5 IRQ_STAT   R/W1C
//    6 SET        W; OR wr_data into DATA_OUT; reads 0
//    7 CLR        W; AND ~wr_data into DATA_OUT; reads 0
//  Bits above NGPIO read 0, and writes to them are dropped.
//  Write: takes effect on the clk edge where wr_stb=1. gpio_out/gpio_oe change at that same edge.
//  Read: rd_data and rd_valid are registered 1 cycle after rd_stb. rd_data holds until the next read.
//  Simultaneous rd_stb and wr_stb to the same register: the read returns the pre-write value.
//  Input path: 2-FF synchronizer, then a third flop for edge detection.
//    PIN_IN reflects the 2nd stage: 2-cycle latency.
//    A detected edge of the selected polarity sets IRQ_STAT[i] only when IRQ_EN[i]=1.
//    This prevents spurious status bits after reset.
//  Same cycle W1C and new edge on the same bit: set wins, and the bit stays 1.
//  Reading IRQ_STAT does not clear it.
//  Clearing IRQ_EN[i] does not clear IRQ_STAT[i]; it only masks it.
//  irq is registered: irq <= |(IRQ_STAT & IRQ_EN).
//    Asserts 1 cycle after the status bit sets.
//    Deasserts 1 cycle after the clearing write.
//  Reset asserted mid-operation: immediate return to reset values; no pending read completes.
// STRUCTURE
//  Package sram_gpio_pkg holds:
//    register offset localparams (REG_DATA_OUT..REG_CLR)
//    BLOCK_SEL default
//    bus data width constant (8)
//  Sub-module gpio_edge_sync (parameter NGPIO): per-bit 2-FF sync plus edge flop.
//    Outputs: sync value, rise pulse, fall pulse.
//  Top level: decode, register file, read mux/register, irq logic.
// TESTING
//  1. Reset with gpio_in=8'hFF -> all outputs 0; IRQ_STAT stays 0 for 10 cycles; irq=0.
//  2. Write DIR=8'h0F, DATA_OUT=8'hA5 -> gpio_oe=8'h0F, gpio_out=8'hA5 the same edge.
//     Read 0 -> rd_data=8'hA5 with rd_valid 1 cycle after rd_stb.
//  3. SET 8'h02 then CLR 8'h81 from DATA_OUT=8'h00.
//     -> readback 8'h02 after SET, 8'h02 after CLR (CLR clears bits 7 and 0, which are already 0).
//  4. IRQ_EN=8'h01, IRQ_EDGE=8'h01; gpio_in[0] goes 0->1 -> IRQ_STAT=8'h01 after 3 cycles, irq 1 cycle later.
//     W1C 8'h01 -> irq=0 next cycle.
//  5. W1C of bit 0 issued in the same cycle as a new rising edge on bit 0 -> IRQ_STAT[0] stays 1, irq stays 1.
//  6. Write with addr[12:3]!=BLOCK_SEL -> no register change.
//     Unselected read -> rd_data=0, rd_valid pulses.
//     Reset pulsed mid-sequence -> all values return to 0.

Source files
------------

// File: rtl/sram_gpio_pkg.sv
// Shared constants for the SRAM-bus GPIO register bank: register offsets,
// default bank select and bus data width.
package sram_gpio_pkg;

  localparam int BUS_W = 8;

  localparam logic [9:0] BLOCK_SEL_DEFAULT = 10'h000;

  localparam logic [2:0] REG_DATA_OUT = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_PIN_IN   = 3'd2;
  localparam logic [2:0] REG_IRQ_EN   = 3'd3;
  localparam logic [2:0] REG_IRQ_EDGE = 3'd4;
  localparam logic [2:0] REG_IRQ_STAT = 3'd5;
  localparam logic [2:0] REG_SET      = 3'd6;
  localparam logic [2:0] REG_CLR      = 3'd7;

endpackage

// File: rtl/sram_gpio_regs_if.sv
// SRAM-bus strobe interface between sram_bus (master) and a register bank (slave).
interface sram_gpio_regs_if #(parameter int ADDR_W = 13);
  import sram_gpio_pkg::*;

  logic              wr_stb;
  logic              rd_stb;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  wr_data;
  logic [BUS_W-1:0]  rd_data;
  logic              rd_valid;

  modport master (output wr_stb, rd_stb, addr, wr_data, input rd_data, rd_valid);
  modport slave  (input wr_stb, rd_stb, addr, wr_data, output rd_data, rd_valid);

endinterface

// File: rtl/gpio_edge_sync.sv
// Per-bit two-flop synchronizer for asynchronous pins, plus a third flop that
// turns the synchronized value into one-cycle rise/fall pulses.
module gpio_edge_sync #(
  parameter int NGPIO = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NGPIO-1:0] gpio_in,
  output logic [NGPIO-1:0] sync,
  output logic [NGPIO-1:0] rise,
  output logic [NGPIO-1:0] fall
);

  logic [NGPIO-1:0] stage1, stage2, stage3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage1 <= '0;
      stage2 <= '0;
      stage3 <= '0;
    end else begin
      stage1 <= gpio_in;
      stage2 <= stage1;
      stage3 <= stage2;
    end
  end

  assign sync = stage2;
  assign rise = stage2 & ~stage3;
  assign fall = ~stage2 & stage3;

endmodule

// File: rtl/sram_gpio_regs.sv
// GPIO register bank on the SRAM bus: data/direction registers, synchronized
// pin readback and an edge-triggered maskable interrupt.
module sram_gpio_regs
  import sram_gpio_pkg::*;
#(
  parameter int                NGPIO     = 8,
  parameter int                ADDR_W    = 13,
  parameter logic [ADDR_W-4:0] BLOCK_SEL = BLOCK_SEL_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  sram_gpio_regs_if.slave   bus,
  input  logic [NGPIO-1:0]  gpio_in,
  output logic [NGPIO-1:0]  gpio_out,
  output logic [NGPIO-1:0]  gpio_oe,
  output logic              irq
);

  logic [NGPIO-1:0] irq_en, irq_edge, irq_stat;
  logic [NGPIO-1:0] pin_sync, pin_rise, pin_fall;
  logic [NGPIO-1:0] wr_val, w1c_mask, edge_hit;
  logic [BUS_W-1:0] rd_word;
  logic [2:0]       offset;
  logic             selected, wr_hit;

  gpio_edge_sync #(.NGPIO(NGPIO)) u_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .gpio_in (gpio_in),
    .sync    (pin_sync),
    .rise    (pin_rise),
    .fall    (pin_fall)
  );

  assign selected = (bus.addr[ADDR_W-1:3] == BLOCK_SEL);
  assign offset   = bus.addr[2:0];
  assign wr_hit   = bus.wr_stb && selected;
  assign wr_val   = bus.wr_data[NGPIO-1:0];
  assign w1c_mask = (wr_hit && offset == REG_IRQ_STAT) ? wr_val : '0;
  assign edge_hit = irq_en & ((irq_edge & pin_rise) | (~irq_edge & pin_fall));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
      irq_en   <= '0;
      irq_edge <= '0;
    end else if (wr_hit) begin
      unique case (offset)
        REG_DATA_OUT: gpio_out <= wr_val;
        REG_DIR:      gpio_oe  <= wr_val;
        REG_IRQ_EN:   irq_en   <= wr_val;
        REG_IRQ_EDGE: irq_edge <= wr_val;
        REG_SET:      gpio_out <= gpio_out | wr_val;
        REG_CLR:      gpio_out <= gpio_out & ~wr_val;
        default:      ;
      endcase
    end
  end

  // A fresh edge is ORed in after the W1C mask so a coincident set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      irq_stat <= (irq_stat & ~w1c_mask) | edge_hit;
      irq      <= |(irq_stat & irq_en);
    end
  end

  always_comb begin
    rd_word = '0;
    if (selected) begin
      unique case (offset)
        REG_DATA_OUT: rd_word[NGPIO-1:0] = gpio_out;
        REG_DIR:      rd_word[NGPIO-1:0] = gpio_oe;
        REG_PIN_IN:   rd_word[NGPIO-1:0] = pin_sync;
        REG_IRQ_EN:   rd_word[NGPIO-1:0] = irq_en;
        REG_IRQ_EDGE: rd_word[NGPIO-1:0] = irq_edge;
        REG_IRQ_STAT: rd_word[NGPIO-1:0] = irq_stat;
        default:      rd_word = '0;
      endcase
    end
  end

  // Read data is captured from the pre-edge registers, so a same-cycle write is not visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_stb;
      if (bus.rd_stb) begin
        bus.rd_data <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_sram_gpio_regs.sv
// Self-checking bench for sram_gpio_regs: directed scenarios plus random bus
// and pin traffic compared against a behavioural register-bank model.
module tb_sram_gpio_regs;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out, gpio_oe;
  logic       irq;

  sram_gpio_regs_if #(.ADDR_W(13)) bus ();

  sram_gpio_regs #(.NGPIO(8), .ADDR_W(13), .BLOCK_SEL(10'h000)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: register contents plus the history of pin values seen at past edges.
  logic [7:0] m_data, m_dir, m_en, m_edge, m_stat, m_rd_data;
  logic       m_irq, m_rd_valid;
  logic [7:0] pin_hist [$];
  logic [7:0] pins;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hist_at(input int idx);
    return (idx < pin_hist.size()) ? pin_hist[idx] : 8'h00;
  endfunction

  task automatic modelReset();
    m_data = 0; m_dir = 0; m_en = 0; m_edge = 0; m_stat = 0;
    m_rd_data = 0; m_irq = 0; m_rd_valid = 0;
    pin_hist.delete();
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".gpio_out"}, gpio_out, m_data);
    checkOutput({tag, ".gpio_oe"}, gpio_oe, m_dir);
    checkOutput({tag, ".irq"}, irq, m_irq);
    checkOutput({tag, ".rd_valid"}, bus.rd_valid, m_rd_valid);
    checkOutput({tag, ".rd_data"}, bus.rd_data, m_rd_data);
  endtask

  // One bus cycle: drive at negedge, predict the post-edge state, check at the next negedge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [12:0] a,
                               input logic [7:0] d, input logic [7:0] p, input string tag);
    logic       sel;
    logic [7:0] visible_pins, older_pins, rise, fall, hits, w1c, rd_val;
    bus.wr_stb = wr; bus.rd_stb = rd; bus.addr = a; bus.wr_data = d;
    gpio_in = p; pins = p;
    sel          = (a[12:3] == 10'h000);
    visible_pins = hist_at(1);
    older_pins   = hist_at(2);
    rise = visible_pins & ~older_pins;
    fall = ~visible_pins & older_pins;
    hits = m_en & ((m_edge & rise) | (~m_edge & fall));
    if (rd) begin
      rd_val = 8'h00;
      if (sel) begin
        case (a[2:0])
          3'd0: rd_val = m_data;
          3'd1: rd_val = m_dir;
          3'd2: rd_val = visible_pins;
          3'd3: rd_val = m_en;
          3'd4: rd_val = m_edge;
          3'd5: rd_val = m_stat;
          default: rd_val = 8'h00;
        endcase
      end
      m_rd_data = rd_val;
    end
    m_rd_valid = rd;
    m_irq = |(m_stat & m_en);
    w1c = 8'h00;
    if (wr && sel) begin
      case (a[2:0])
        3'd0: m_data = d;
        3'd1: m_dir  = d;
        3'd3: m_en   = d;
        3'd4: m_edge = d;
        3'd5: w1c    = d;
        3'd6: m_data = m_data | d;
        3'd7: m_data = m_data & ~d;
        default: ;
      endcase
    end
    m_stat = (m_stat & ~w1c) | hits;
    pin_hist.push_front(p);
    if (pin_hist.size() > 4) void'(pin_hist.pop_back());
    @(posedge clk);
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 13'h0, 8'h00, pins, "idle");
  endtask

  task automatic wrReg(input logic [2:0] off, input logic [7:0] d);
    applyStimulus(1'b1, 1'b0, {10'h000, off}, d, pins, "write");
  endtask

  task automatic rdReg(input logic [2:0] off);
    applyStimulus(1'b0, 1'b1, {10'h000, off}, 8'h00, pins, "read");
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".gpio_out"}, gpio_out, 8'h00);
    checkOutput({tag, ".gpio_oe"}, gpio_oe, 8'h00);
    checkOutput({tag, ".irq"}, irq, 1'b0);
    checkOutput({tag, ".rd_valid"}, bus.rd_valid, 1'b0);
    checkOutput({tag, ".rd_data"}, bus.rd_data, 8'h00);
  endtask

  initial begin
    logic        r_wr, r_rd;
    logic [12:0] r_addr;
    logic [7:0]  r_pins;

    reset = 1'b1;
    bus.wr_stb = 0; bus.rd_stb = 0; bus.addr = 0; bus.wr_data = 0;
    gpio_in = 8'hFF; pins = 8'hFF;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;

    // Pins high out of reset must not latch status while IRQ_EN is 0.
    idle(10);
    rdReg(3'd5);
    checkOutput("t1.irq_stat", bus.rd_data, 8'h00);

    wrReg(3'd1, 8'h0F);
    checkOutput("t2.gpio_oe", gpio_oe, 8'h0F);
    wrReg(3'd0, 8'hA5);
    checkOutput("t2.gpio_out", gpio_out, 8'hA5);
    rdReg(3'd0);
    checkOutput("t2.rd_valid", bus.rd_valid, 1'b1);
    checkOutput("t2.rd_data", bus.rd_data, 8'hA5);
    idle(1);
    checkOutput("t2.rd_valid_drop", bus.rd_valid, 1'b0);
    checkOutput("t2.rd_data_hold", bus.rd_data, 8'hA5);

    wrReg(3'd0, 8'h00);
    wrReg(3'd6, 8'h02);
    rdReg(3'd0);
    checkOutput("t3.after_set", bus.rd_data, 8'h02);
    wrReg(3'd7, 8'h81);
    rdReg(3'd0);
    checkOutput("t3.after_clr", bus.rd_data, 8'h02);

    wrReg(3'd3, 8'h01);
    wrReg(3'd4, 8'h01);
    pins = 8'h00;
    idle(4);
    pins = 8'h01;
    idle(2);
    checkOutput("t4.irq_early", irq, 1'b0);
    idle(1);
    checkOutput("t4.irq_not_yet", irq, 1'b0);
    rdReg(3'd5);
    checkOutput("t4.irq_stat", bus.rd_data, 8'h01);
    checkOutput("t4.irq_set", irq, 1'b1);
    wrReg(3'd5, 8'h01);
    idle(1);
    checkOutput("t4.irq_cleared", irq, 1'b0);

    pins = 8'h00; idle(3);
    pins = 8'h01; idle(4);
    checkOutput("t5.irq_armed", irq, 1'b1);
    pins = 8'h00; idle(3);
    pins = 8'h01; idle(2);
    wrReg(3'd5, 8'h01);
    checkOutput("t5.irq_hold", irq, 1'b1);
    rdReg(3'd5);
    checkOutput("t5.stat_kept", bus.rd_data, 8'h01);
    checkOutput("t5.irq_still", irq, 1'b1);

    applyStimulus(1'b1, 1'b0, {10'h001, 3'd0}, 8'hFF, pins, "t6.unsel_wr");
    checkOutput("t6.gpio_out", gpio_out, 8'h02);
    applyStimulus(1'b0, 1'b1, {10'h155, 3'd0}, 8'h00, pins, "t6.unsel_rd");
    checkOutput("t6.unsel_valid", bus.rd_valid, 1'b1);
    checkOutput("t6.unsel_data", bus.rd_data, 8'h00);

    // Reset lands between the read strobe and its edge, so the read must never complete.
    rdReg(3'd0);
    bus.rd_stb = 1'b1; bus.addr = 13'h0000;
    #2 reset = 1'b1;
    #1 checkResetValues("t6.async_reset");
    @(posedge clk);
    @(negedge clk);
    checkResetValues("t6.reset_held");
    bus.rd_stb = 1'b0;
    modelReset();
    reset = 1'b0;

    for (int i = 0; i < 1500; i++) begin
      r_wr   = ($urandom_range(0, 2) == 0);
      r_rd   = ($urandom_range(0, 2) == 0);
      r_addr = {(($urandom_range(0, 7) == 0) ? 10'($urandom_range(1, 1023)) : 10'h000),
                3'($urandom_range(0, 7))};
      r_pins = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pins;
      applyStimulus(r_wr, r_rd, r_addr, 8'($urandom), r_pins, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
